// File: rtl/axi4_lite_slv_reg_file_pkg.sv
// axi4_lite_slv_reg_file_pkg: shared response encodings and address decode helper
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   addr_lsb()              : byte-offset bits below the register index for a data width
package axi4_lite_slv_reg_file_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int addr_lsb(input int data_bit_width);
        return $clog2(data_bit_width / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// axi4_lite_strb_merge: combinational byte-strobe merge
//   old_word : current register contents
//   new_word : incoming write data
//   strb     : per-byte enables, 1 selects the new byte
//   merged   : resulting word
module axi4_lite_strb_merge #(
    parameter int DATA_BIT_WIDTH = 32
) (
    input  logic [DATA_BIT_WIDTH-1:0]   old_word,
    input  logic [DATA_BIT_WIDTH-1:0]   new_word,
    input  logic [DATA_BIT_WIDTH/8-1:0] strb,
    output logic [DATA_BIT_WIDTH-1:0]   merged
);

    for (genvar b = 0; b < DATA_BIT_WIDTH / 8; b++) begin : g_byte
        assign merged[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end

endmodule

// File: rtl/axi4_lite_slv_reg_file.sv
// axi4_lite_slv_reg_file: AXI4-Lite slave with NUM_REGS read/write control registers
//   clk, sync_rst              : clock and synchronous active-high reset
//   aw*/w*/b*                  : AXI4-Lite write address, data and response channels
//   ar*/r*                     : AXI4-Lite read address and data channels
//   reg_out                    : flat register contents, reg i at [i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH]
//   Define AXI4_LITE_SLV_REG_FILE_ADDR_ERR_RESP_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_slv_reg_file
    import axi4_lite_slv_reg_file_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS       = 4
) (
    input  logic                               clk,
    input  logic                               sync_rst,
    input  logic [ADDR_BIT_WIDTH-1:0]          awaddr,
    input  logic [2:0]                         awprot,
    input  logic                               awvalid,
    output logic                               awready,
    input  logic [DATA_BIT_WIDTH-1:0]          wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0]        wstrb,
    input  logic                               wvalid,
    output logic                               wready,
    output logic [1:0]                         bresp,
    output logic                               bvalid,
    input  logic                               bready,
    input  logic [ADDR_BIT_WIDTH-1:0]          araddr,
    input  logic [2:0]                         arprot,
    input  logic                               arvalid,
    output logic                               arready,
    output logic [DATA_BIT_WIDTH-1:0]          rdata,
    output logic [1:0]                         rresp,
    output logic                               rvalid,
    input  logic                               rready,
    output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] reg_out
);

    localparam int ADDR_LSB = addr_lsb(DATA_BIT_WIDTH);
    localparam logic [ADDR_BIT_WIDTH-1:0] NUM_REGS_A = ADDR_BIT_WIDTH'(NUM_REGS);
`ifdef AXI4_LITE_SLV_REG_FILE_ADDR_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic                        aw_held, w_held;
    logic [ADDR_BIT_WIDTH-1:0]   aw_addr_q;
    logic [DATA_BIT_WIDTH-1:0]   w_data_q;
    logic [DATA_BIT_WIDTH/8-1:0] w_strb_q;
    logic [DATA_BIT_WIDTH-1:0]   regs   [NUM_REGS];
    logic [DATA_BIT_WIDTH-1:0]   merged [NUM_REGS];
    logic                        aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_BIT_WIDTH-1:0]   w_idx, r_idx;
    logic [DATA_BIT_WIDTH-1:0]   w_word, rd_word;
    logic [DATA_BIT_WIDTH/8-1:0] w_strb;
    logic                        w_in_range, r_in_range;
    logic                        unused;

    assign unused  = ^{awprot, arprot};
    assign awready = !aw_held && !bvalid && !sync_rst;
    assign wready  = !w_held && !bvalid && !sync_rst;
    assign arready = !rvalid && !sync_rst;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    // A held beat takes precedence over the live bus so a half-arrived write completes with its own fields
    assign commit     = (aw_held || aw_hs) && (w_held || w_hs);
    assign w_idx      = (aw_held ? aw_addr_q : awaddr) >> ADDR_LSB;
    assign w_word     = w_held ? w_data_q : wdata;
    assign w_strb     = w_held ? w_strb_q : wstrb;
    assign w_in_range = w_idx < NUM_REGS_A;
    assign r_idx      = araddr >> ADDR_LSB;
    assign r_in_range = r_idx < NUM_REGS_A;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        axi4_lite_strb_merge #(.DATA_BIT_WIDTH(DATA_BIT_WIDTH)) u_merge (
            .old_word(regs[g]),
            .new_word(w_word),
            .strb    (w_strb),
            .merged  (merged[g])
        );
        assign reg_out[g*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = regs[g];
    end

    // Out-of-range indices match no register and read back as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (r_idx == ADDR_BIT_WIDTH'(i)) rd_word = regs[i];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++)
            if (sync_rst) regs[i] <= '0;
            else if (commit && w_idx == ADDR_BIT_WIDTH'(i)) regs[i] <= merged[i];
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= w_in_range ? RESP_OKAY : OOR_RESP;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
            rresp  <= r_in_range ? RESP_OKAY : OOR_RESP;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// tb_axi4_lite_slv_reg_file: directed self-checking bench for axi4_lite_slv_reg_file
module tb_axi4_lite_slv_reg_file;

`ifdef AXI4_LITE_SLV_REG_FILE_ADDR_ERR_RESP_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic         clk = 1'b0;
    logic         sync_rst;
    logic [31:0]  awaddr, wdata, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]   wstrb;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] reg_out;
    int           n_asserts = 0;
    int           n_fail = 0;

    axi4_lite_slv_reg_file dut (
        .clk(clk), .sync_rst(sync_rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] resp);
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b0;
        tick();
        chk("wr_bvalid", 128'(bvalid), 128'(1'b1));
        chk("wr_bresp", 128'(bresp), 128'(resp));
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        chk("wr_bvalid_clr", 128'(bvalid), 128'(1'b0));
    endtask

    task automatic read_chk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        tick();
        chk("rd_rvalid", 128'(rvalid), 128'(1'b1));
        chk("rd_rdata", 128'(rdata), 128'(d));
        chk("rd_rresp", 128'(rresp), 128'(resp));
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        tick();
        chk("rd_rvalid_clr", 128'(rvalid), 128'(1'b0));
    endtask

    initial begin
        sync_rst = 1'b1;
        awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (2) tick();
        chk("rst_awready", 128'(awready), 128'(1'b0));
        chk("rst_wready", 128'(wready), 128'(1'b0));
        chk("rst_arready", 128'(arready), 128'(1'b0));
        chk("rst_bvalid", 128'(bvalid), 128'(1'b0));
        chk("rst_rvalid", 128'(rvalid), 128'(1'b0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        chk("rst_reg_out", reg_out, 128'(0));
        @(negedge clk);
        sync_rst = 1'b0;
        tick();
        chk("idle_awready", 128'(awready), 128'(1'b1));
        chk("idle_wready", 128'(wready), 128'(1'b1));
        chk("idle_arready", 128'(arready), 128'(1'b1));
        chk("idle_reg_out", reg_out, 128'(0));

        write_both(32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
        chk("reg1_write", 128'(reg_out[63:32]), 128'(32'hDEADBEEF));
        read_chk(32'h4, 32'hDEADBEEF, 2'b00);

        write_both(32'h8, 32'hFFFFFFFF, 4'hF, 2'b00);
        @(negedge clk);
        wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1; bready = 1'b0;
        tick();
        chk("w_first_wready", 128'(wready), 128'(1'b0));
        chk("w_first_awready", 128'(awready), 128'(1'b1));
        @(negedge clk);
        wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
        tick();
        chk("w_wait_wready", 128'(wready), 128'(1'b0));
        chk("w_wait_bvalid", 128'(bvalid), 128'(1'b0));
        @(negedge clk);
        awaddr = 32'h8; awvalid = 1'b1;
        tick();
        chk("w_first_bvalid", 128'(bvalid), 128'(1'b1));
        chk("reg2_strb", 128'(reg_out[95:64]), 128'(32'hFFFF5678));
        @(negedge clk);
        awvalid = 1'b0; bready = 1'b1;
        tick();
        chk("w_first_bclr", 128'(bvalid), 128'(1'b0));

        @(negedge clk);
        awaddr = 32'hC; awvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        tick();
        @(negedge clk);
        awaddr = 32'h0; wdata = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bstall_bvalid", 128'(bvalid), 128'(1'b1));
            chk("bstall_bresp", 128'(bresp), 128'(2'b00));
            chk("bstall_awready", 128'(awready), 128'(1'b0));
            chk("bstall_wready", 128'(wready), 128'(1'b0));
        end
        chk("bstall_reg0", 128'(reg_out[31:0]), 128'(0));
        @(negedge clk);
        bready = 1'b1;
        tick();
        chk("bdone_bvalid", 128'(bvalid), 128'(1'b0));
        chk("bdone_awready", 128'(awready), 128'(1'b1));
        chk("bdone_reg0", 128'(reg_out[31:0]), 128'(0));
        tick();
        chk("next_bvalid", 128'(bvalid), 128'(1'b1));
        chk("next_reg0", 128'(reg_out[31:0]), 128'(32'h11111111));
        chk("next_reg3", 128'(reg_out[127:96]), 128'(32'hA5A5A5A5));
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("next_bclr", 128'(bvalid), 128'(1'b0));

        @(negedge clk);
        araddr = 32'hC; arvalid = 1'b1; rready = 1'b0;
        tick();
        chk("rstall_first", 128'(rdata), 128'(32'hA5A5A5A5));
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstall_rvalid", 128'(rvalid), 128'(1'b1));
            chk("rstall_rdata", 128'(rdata), 128'(32'hA5A5A5A5));
            chk("rstall_rresp", 128'(rresp), 128'(2'b00));
            chk("rstall_arready", 128'(arready), 128'(1'b0));
        end
        @(negedge clk);
        rready = 1'b1;
        tick();
        chk("rdone_rvalid", 128'(rvalid), 128'(1'b0));
        chk("rdone_arready", 128'(arready), 128'(1'b1));

        write_both(32'h40, 32'hCAFEF00D, 4'hF, EXP_OOR);
        chk("oor_regs", reg_out, {32'hA5A5A5A5, 32'hFFFF5678, 32'hDEADBEEF, 32'h11111111});
        read_chk(32'h40, 32'h0, EXP_OOR);

        @(negedge clk);
        awaddr = 32'h4; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
        tick();
        chk("rw_rdata_old", 128'(rdata), 128'(32'hDEADBEEF));
        chk("rw_reg1_new", 128'(reg_out[63:32]), 128'(32'h0BADF00D));
        chk("rw_bvalid", 128'(bvalid), 128'(1'b1));
        chk("rw_rvalid", 128'(rvalid), 128'(1'b1));
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        tick();
        chk("rw_bclr", 128'(bvalid), 128'(1'b0));
        chk("rw_rclr", 128'(rvalid), 128'(1'b0));

        write_both(32'h0, 32'hAB000000, 4'h8, 2'b00);
        chk("reg0_top_byte", 128'(reg_out[31:0]), 128'(32'hAB111111));
        read_chk(32'h8, 32'hFFFF5678, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
